// File: rtl/onion_pwm_pkg.sv
// Shared constants for the onion PWM blocks: capture FSM state encodings and the
// default counter width, also used by the breathe generator so loopback tests agree.
package onion_pwm_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MEAS = 1'b1;

endpackage

// File: rtl/onion_sync_edge.sv
// Synchronizer for an asynchronous input plus a delay flop, producing the
// synchronized level and registered single-cycle rise/fall pulses.
module onion_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Edge pulses are registered so they line up with d_q, which is the level
  // reported alongside them; this puts capture SYNC_STAGES+1 edges after the input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      d_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      d_q    <= s;
      rise_q <= s & ~d_q;
      fall_q <= ~s & d_q;
    end
  end

  assign s_o    = d_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/onion_pwm_capture.sv
// PWM capture: measures period and high time of pwm_i in clock cycles and flags
// a stuck line when no rising edge arrives before the counter saturates.
module onion_pwm_capture
  import onion_pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             level_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s;
  logic             rise;
  logic             fall;

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcap_q, hcap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             level_q, level_d;

  logic [CNT_W:0]   cnt_plus;
  logic [CNT_W-1:0] cnt_sat;

  onion_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .async_i(pwm_i),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  // A full 2^CNT_W period cannot be represented, so cnt+1 clamps to all-ones.
  assign cnt_plus = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_sat  = cnt_plus[CNT_W] ? CNT_MAX : cnt_plus[CNT_W-1:0];

  always_comb begin
    cnt_d    = rise ? '0 : cnt_sat;
    hcap_d   = fall ? cnt_sat : hcap_q;
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    level_d  = level_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEAS;
          stuck_d = 1'b0;
        end
      end
      ST_MEAS: begin
        // A rise on the saturation cycle still completes the measurement.
        if (rise) begin
          period_d = cnt_sat;
          high_d   = hcap_q;
          valid_d  = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          stuck_d = 1'b1;
          level_d = s;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcap_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcap_q   <= hcap_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      level_q  <= level_d;
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign stuck_o  = stuck_q;
  assign level_o  = level_q;

endmodule
